// File: rtl/lfsr_frame_ctrl.sv
// Sequencer for the 32-bit LFSR pattern generator: seeds the LFSR, captures one word per frame and
// streams it as eight tagged bytes over a valid/ready link. Optional macro: LFSR_ZERO_GUARD_EN.
module lfsr_frame_ctrl #(
  parameter int          CNT_W        = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'h1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic             lfsr_load,
  output logic [31:0]      lfsr_seed,
  output logic             lfsr_step,
  input  logic [31:0]      lfsr_q,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] words_sent
);

`ifdef LFSR_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [2:0] {INIT, IDLE, LOAD, CAPT, SEND, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_r;
  logic             start_pend;
  logic [2:0]       idx;
  logic [31:0]      frame;
  logic [31:0]      q_next;
  logic             cap_zero;
  logic [31:0]      capt_q;
  logic [CNT_W-1:0] ws_inc;

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (ZERO_GUARD && (s == 32'h0)) ? 32'h1 : s;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [31:0] q, input logic [2:0] k);
    case (k)
      3'd7:    return 8'b111_00000;
      3'd6:    return {3'b110, q[31:29], 2'b00};
      3'd5:    return {3'b101, q[28:24]};
      3'd4:    return {3'b100, q[23:19]};
      3'd3:    return {3'b011, q[18:14]};
      3'd2:    return {3'b010, q[13:9]};
      3'd1:    return {3'b001, q[8:4]};
      default: return {3'b000, q[3:0], 1'b1};
    endcase
  endfunction

  // Value the LFSR will hold during the upcoming CAPT cycle; a pending load lands on this edge.
  assign q_next   = lfsr_load ? lfsr_seed : lfsr_q;
  assign cap_zero = ZERO_GUARD && (q_next == 32'h0);
  assign capt_q   = (ZERO_GUARD && (lfsr_q == 32'h0)) ? 32'h1 : lfsr_q;
  assign ws_inc   = words_sent + ONE;

  always_ff @(posedge clk) begin
    if (state == CAPT) frame <= capt_q;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= INIT;
      lfsr_load  <= 1'b0;
      lfsr_seed  <= SEED_DEFAULT;
      lfsr_step  <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
      n_r        <= '0;
      start_pend <= 1'b0;
      idx        <= 3'd0;
    end else begin
      lfsr_load <= 1'b0;
      lfsr_step <= 1'b0;
      done      <= 1'b0;
      case (state)
        INIT: begin
          lfsr_load <= 1'b1;
          lfsr_seed <= SEED_DEFAULT;
          state     <= IDLE;
        end
        IDLE: begin
          if (start) begin
            n_r        <= num_words;
            words_sent <= '0;
          end
          if (seed_load) begin
            state      <= LOAD;
            busy       <= 1'b1;
            lfsr_load  <= 1'b1;
            lfsr_seed  <= seed_fix(seed);
            start_pend <= start;
          end else if (start) begin
            busy <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
            end else begin
              state     <= CAPT;
              lfsr_step <= !cap_zero;
              lfsr_load <= cap_zero;
              if (cap_zero) lfsr_seed <= 32'h1;
            end
          end
        end
        LOAD: begin
          start_pend <= 1'b0;
          if (!start_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (n_r == '0) begin
            state <= DONE;
          end else begin
            state     <= CAPT;
            lfsr_step <= !cap_zero;
            lfsr_load <= cap_zero;
            if (cap_zero) lfsr_seed <= 32'h1;
          end
        end
        CAPT: begin
          state    <= SEND;
          tx_valid <= 1'b1;
          tx_data  <= frame_byte(capt_q, 3'd7);
          idx      <= 3'd7;
        end
        SEND: begin
          // Abort is only looked at once the whole frame has gone out.
          if (tx_ready) begin
            if (idx == 3'd0) begin
              words_sent <= ws_inc;
              tx_valid   <= 1'b0;
              if ((ws_inc == n_r) || abort) begin
                state <= DONE;
              end else begin
                state     <= CAPT;
                lfsr_step <= !cap_zero;
                lfsr_load <= cap_zero;
                if (cap_zero) lfsr_seed <= 32'h1;
              end
            end else begin
              idx     <= idx - 3'd1;
              tx_data <= frame_byte(frame, idx - 3'd1);
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_frame_ctrl.sv
// Scoreboard bench for lfsr_frame_ctrl: a stub LFSR answers the strobes, expected frame bytes are
// queued when a run is started and popped as the sink accepts bytes.
module tb_lfsr_frame_ctrl;
  localparam int          CNT_W        = 16;
  localparam logic [31:0] SEED_DEFAULT = 32'h1;
`ifdef LFSR_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             abort = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = 32'h0;
  logic             lfsr_load;
  logic [31:0]      lfsr_seed;
  logic             lfsr_step;
  logic [31:0]      lfsr_q = 32'h0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] words_sent;

  lfsr_frame_ctrl #(.CNT_W(CNT_W), .SEED_DEFAULT(SEED_DEFAULT)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .num_words(num_words), .abort(abort),
    .seed_load(seed_load), .seed(seed), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed),
    .lfsr_step(lfsr_step), .lfsr_q(lfsr_q), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          step_cnt = 0;
  int          rdy_mode = 1;
  logic [31:0] ref_q;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_byte = 8'h00;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] q, input int k);
    logic [4:0]  pay;
    logic [31:0] sh;
    if (k == 7)      pay = 5'd0;
    else if (k == 6) pay = {q[31:29], 2'b00};
    else if (k == 0) pay = {q[3:0], 1'b1};
    else begin
      sh  = q >> (4 + 5 * (k - 1));
      pay = sh[4:0];
    end
    return {3'(k), pay};
  endfunction

  // Stub LFSR driven by the DUT strobes.
  always @(posedge clk) begin
    if (lfsr_load) lfsr_q <= lfsr_seed;
    else if (lfsr_step) begin
      lfsr_q <= lfsr_next(lfsr_q);
      step_cnt <= step_cnt + 1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        2:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (clr_n) begin
      if (prev_stall) begin
        check("stall_valid", tx_valid, 1'b1);
        check("stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("queue_underrun", exp_q.size(), 1);
        else check("byte", tx_data, exp_q.pop_front());
        last_byte = tx_data;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frames(input int nexp);
    logic [31:0] w;
    for (int i = 0; i < nexp; i++) begin
      if (GUARD && ref_q == 32'h0) begin
        w     = 32'h1;
        ref_q = 32'h1;
      end else begin
        w     = ref_q;
        ref_q = lfsr_next(ref_q);
      end
      for (int k = 7; k >= 0; k--) exp_q.push_back(ref_byte(w, k));
    end
  endtask

  task automatic go(input int n, input bit ld, input logic [31:0] s, input int nexp);
    if (ld) ref_q = (GUARD && s == 32'h0) ? 32'h1 : s;
    push_frames(nexp);
    num_words = CNT_W'(n);
    start     = 1'b1;
    seed_load = ld;
    seed      = s;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_done"}, seen, 1'b1);
    if (seen) begin
      tick();
      check({tag, "_done_width"}, done, 1'b0);
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sb;
    bit  found;
    ref_q = SEED_DEFAULT;
    repeat (3) tick();
    check("rst_load", lfsr_load, 1'b0);
    check("rst_step", lfsr_step, 1'b0);
    check("rst_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_words", words_sent, 0);
    check("rst_seed", lfsr_seed, SEED_DEFAULT);

    clr_n = 1'b1;
    tick();
    check("init_load", lfsr_load, 1'b1);
    check("init_seed", lfsr_seed, 32'h1);
    tick();
    check("init_load_off", lfsr_load, 1'b0);
    check("init_busy", busy, 1'b0);

    // explicit seed, one word, sink always ready
    go(1, 1'b1, 32'hDEADBEEF, 1);
    check("seed_strobe", lfsr_load, 1'b1);
    check("seed_value", lfsr_seed, 32'hDEADBEEF);
    check("seed_busy", busy, 1'b1);
    wait_done("seed_run", 100);
    check("seed_words", words_sent, 1);
    check("seed_idle", busy, 1'b0);

    // three words with a stalling sink
    rdy_mode = 2;
    sb = step_cnt;
    go(3, 1'b0, 32'h0, 3);
    check("lat_cycle1", tx_valid, 1'b0);
    tick();
    check("lat_cycle2", tx_valid, 1'b1);
    wait_done("toggle_run", 400);
    check("toggle_steps", step_cnt - sb, 3);
    check("toggle_words", words_sent, 3);

    // zero-length run
    rdy_mode = 1;
    go(0, 1'b0, 32'h0, 0);
    check("n0_done_early", done, 1'b0);
    check("n0_valid_a", tx_valid, 1'b0);
    tick();
    check("n0_done", done, 1'b1);
    check("n0_valid_b", tx_valid, 1'b0);
    tick();
    check("n0_done_width", done, 1'b0);
    check("n0_words", words_sent, 0);

    // start/seed_load while busy must be ignored
    go(2, 1'b0, 32'h0, 2);
    tick();
    num_words = CNT_W'(7);
    seed      = 32'h1234;
    start     = 1'b1;
    seed_load = 1'b1;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    wait_done("busy_start", 200);
    check("busy_start_words", words_sent, 2);

    // abort raised during byte 4 of the second frame
    sb = step_cnt;
    go(5, 1'b0, 32'h0, 2);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (tx_valid && words_sent == CNT_W'(1) && tx_data[7:5] == 3'd4) found = 1'b1;
      else tick();
    end
    check("abort_reach", found, 1'b1);
    abort = 1'b1;
    wait_done("abort_run", 200);
    abort = 1'b0;
    check("abort_words", words_sent, 2);
    check("abort_steps", step_cnt - sb, 2);

    // random sink backpressure
    rdy_mode = 3;
    go(4, 1'b0, 32'h0, 4);
    wait_done("rand_run", 800);
    check("rand_words", words_sent, 4);

    // reset in the middle of a run
    rdy_mode = 1;
    go(3, 1'b0, 32'h0, 3);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (words_sent == CNT_W'(1)) found = 1'b1;
      else tick();
    end
    check("midrst_reach", found, 1'b1);
    clr_n = 1'b0;
    tick();
    check("midrst_valid", tx_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_words", words_sent, 0);
    exp_q.delete();
    clr_n = 1'b1;
    ref_q = SEED_DEFAULT;
    tick();
    check("midrst_load", lfsr_load, 1'b1);
    check("midrst_seed", lfsr_seed, SEED_DEFAULT);
    tick();
    go(1, 1'b0, 32'h0, 1);
    wait_done("post_rst_run", 100);
    check("post_rst_words", words_sent, 1);

    // all-zero seed
    go(1, 1'b1, 32'h0, 1);
    check("zero_seed_value", lfsr_seed, GUARD ? 32'h1 : 32'h0);
    wait_done("zero_seed_run", 100);
    check("zero_seed_b0", last_byte, GUARD ? 8'h03 : 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
